reset_ctrl: RTL and testbench

RESET_CTRL -- requirements
Module: reset_ctrl

---
 rtl/reset_pkg.sv | 25 ++
 rtl/reset_ctrl_debounce.sv | 57 +++++
 rtl/reset_ctrl.sv | 137 +++++++++++++
 tb/tb_reset_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/reset_pkg.sv
// Shared types and constants for the reset controller.
// Holds the sequencer state type, cause-bit indices and a small helper.
// No ports; imported by reset_ctrl and debounce.
package reset_pkg;

  // Release sequence: everything held, then memory, peripheral, CPU out.
  typedef enum logic [1:0] {
    ST_ASSERT     = 2'd0,
    ST_REL_MEM    = 2'd1,
    ST_REL_PERIPH = 2'd2,
    ST_RUN        = 2'd3
  } state_e;

  // Bit positions inside the sticky cause vector.
  localparam int CAUSE_POR = 0;
  localparam int CAUSE_SW  = 1;
  localparam int CAUSE_WDT = 2;
  localparam int CAUSE_EXT = 3;
  localparam int CAUSE_W   = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_ctrl_debounce.sv
// Two-flop synchroniser plus debounce for an asynchronous active-high input.
// Ports: ck/rst (sync, active-high), din_i async level, level_o debounced
// level, rise_o one-cycle pulse on the DEBOUNCE-th consecutive high cycle.
module debounce
  import reset_pkg::*;
#(
  parameter int DEBOUNCE = 16
) (
  input  logic ck,
  input  logic rst,
  input  logic din_i,
  output logic level_o,
  output logic rise_o
);

  localparam int DB = max_int(DEBOUNCE, 1);
  localparam int CW = $clog2(DB + 1);
  localparam logic [CW-1:0] DB_FULL = CW'(DB);
  localparam logic [CW-1:0] DB_LAST = CW'(DB - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise;

  // The count saturates at DB so a held-high input produces exactly one
  // rise; only a low sample (which zeroes the count) re-arms it.
  always_comb begin
    cnt_d = cnt_q;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != DB_FULL) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise    = sync2_q && (cnt_q == DB_LAST);
  assign level_d = sync2_q && (level_q || rise);

  always_ff @(posedge ck) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise;

endmodule

// File: rtl/reset_ctrl.sv
// Reset sequencer: holds mem/periph/cpu resets, then releases them staged.
// Ports: ck/rst (sync, active-high POR), req_sw/req_wdt pulses, req_ext async
// button, clr_cause; outputs rst_mem, rst_periph, rst_cpu, busy, cause[3:0].
module reset_ctrl
  import reset_pkg::*;
#(
  parameter int HOLD     = 8,
  parameter int STAGE    = 4,
  parameter int DEBOUNCE = 16
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               req_sw,
  input  logic               req_wdt,
  input  logic               req_ext,
  input  logic               clr_cause,
  output logic               rst_mem,
  output logic               rst_periph,
  output logic               rst_cpu,
  output logic               busy,
  output logic [CAUSE_W-1:0] cause
);

  localparam int HOLD_N  = max_int(HOLD, 1);
  localparam int STAGE_N = max_int(STAGE, 1);
  localparam int CNT_MAX = max_int(HOLD_N, STAGE_N);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_N - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_N - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               rst_mem_q, rst_mem_d;
  logic               rst_periph_q, rst_periph_d;
  logic               rst_cpu_q, rst_cpu_d;
  logic               busy_q, busy_d;

  logic ext_level, ext_rise;
  logic ext_acc, any_req;

  debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .ck     (ck),
    .rst    (rst),
    .din_i  (req_ext),
    .level_o(ext_level),
    .rise_o (ext_rise)
  );

  // The debounced level only rises on the edge after the rise pulse, so
  // this qualifier accepts a fresh press and nothing while it is held.
  assign ext_acc = ext_rise && !ext_level;
  assign any_req = req_sw || req_wdt || ext_acc;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;

    if (any_req) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_REL_MEM;
            cnt_d   = '0;
          end
        end
        ST_REL_MEM: begin
          if (cnt_q == STAGE_LAST) begin
            state_d = ST_REL_PERIPH;
            cnt_d   = '0;
          end
        end
        ST_REL_PERIPH: begin
          if (cnt_q == STAGE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are registered from the next state so they move together
    // with the state register.
    rst_mem_d    = (state_d == ST_ASSERT);
    rst_periph_d = (state_d == ST_ASSERT) || (state_d == ST_REL_MEM);
    rst_cpu_d    = (state_d != ST_RUN);
    busy_d       = (state_d != ST_RUN);

    // Clear first, then set, so a request coinciding with clr_cause wins.
    cause_d = cause_q;
    if (clr_cause) begin
      cause_d[CAUSE_EXT:CAUSE_SW] = '0;
    end
    if (req_sw)  cause_d[CAUSE_SW]  = 1'b1;
    if (req_wdt) cause_d[CAUSE_WDT] = 1'b1;
    if (ext_acc) cause_d[CAUSE_EXT] = 1'b1;
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q      <= ST_ASSERT;
      cnt_q        <= '0;
      cause_q      <= CAUSE_W'(1) << CAUSE_POR;
      rst_mem_q    <= 1'b1;
      rst_periph_q <= 1'b1;
      rst_cpu_q    <= 1'b1;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cause_q      <= cause_d;
      rst_mem_q    <= rst_mem_d;
      rst_periph_q <= rst_periph_d;
      rst_cpu_q    <= rst_cpu_d;
      busy_q       <= busy_d;
    end
  end

  assign rst_mem    = rst_mem_q;
  assign rst_periph = rst_periph_q;
  assign rst_cpu    = rst_cpu_q;
  assign busy       = busy_q;
  assign cause      = cause_q;

endmodule

// File: tb/tb_reset_ctrl.sv
// Testbench for reset_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model.
// Model tracks cycles since the last restart and derives outputs from it.
module tb_reset_ctrl;

  localparam int HOLD     = 8;
  localparam int STAGE    = 4;
  localparam int DEBOUNCE = 16;

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic       req_sw = 1'b0, req_wdt = 1'b0, req_ext = 1'b0, clr_cause = 1'b0;
  logic       rst_mem, rst_periph, rst_cpu, busy;
  logic [3:0] cause;

  reset_ctrl #(
    .HOLD(HOLD), .STAGE(STAGE), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .ck        (ck),
    .rst       (rst),
    .req_sw    (req_sw),
    .req_wdt   (req_wdt),
    .req_ext   (req_ext),
    .clr_cause (clr_cause),
    .rst_mem   (rst_mem),
    .rst_periph(rst_periph),
    .rst_cpu   (rst_cpu),
    .busy      (busy),
    .cause     (cause)
  );

  always #5 ck = ~ck;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- behavioural model ----------------
  // age: clock edges since the last rst/accepted request.
  int       m_age   = 0;
  logic [3:0] m_cause = 4'b0001;
  int       m_run   = 0;      // consecutive high cycles of the delayed ext level
  bit       m_valid = 1'b0;
  // req_ext / rst seen one and two edges ago (reset-time history counts as rst)
  logic xh1 = 1'b0, xh2 = 1'b0;
  logic rh1 = 1'b1, rh2 = 1'b1;

  always @(posedge ck) begin
    logic d, acc_ext;
    // The debouncer sees req_ext two edges late; a rst on either of those
    // edges wipes the value in flight.
    d = (!rh1 && !rh2) ? xh2 : 1'b0;
    if (rst) begin
      m_age   = 0;
      m_cause = 4'b0001;
      m_run   = 0;
      m_valid = 1'b1;
    end else begin
      acc_ext = d && (m_run == DEBOUNCE - 1);
      m_run   = d ? m_run + 1 : 0;
      if (req_sw || req_wdt || acc_ext) m_age = 0;
      else if (m_age < 1000) m_age = m_age + 1;
      if (clr_cause) m_cause = m_cause & 4'b0001;
      m_cause = m_cause | {acc_ext, req_wdt, req_sw, 1'b0};
    end
    rh2 = rh1; rh1 = rst;
    xh2 = xh1; xh1 = req_ext;
  end

  // One comparison of the whole output bundle per cycle.
  always @(negedge ck) begin
    logic [7:0] exp_v, act_v;
    if (m_valid) begin
      exp_v = {m_age < HOLD, m_age < HOLD + STAGE, m_age < HOLD + 2 * STAGE,
               m_age < HOLD + 2 * STAGE, m_cause};
      act_v = {rst_mem, rst_periph, rst_cpu, busy, cause};
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL model t=%0t {mem,periph,cpu,busy,cause} got %b expected %b",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge ck);
  endtask

  initial begin
    int   ext_left;
    int   rises;
    logic prev_cpu;

    // Reset for 3 cycles; a request during rst must be ignored.
    req_wdt = 1'b1;
    cyc(1);
    req_wdt = 1'b0;
    cyc(2);
    rst = 1'b0;
    check("reset_outputs", {4'b0, rst_mem, rst_periph, rst_cpu, busy}, 8'h0F);
    check("reset_cause", {4'b0, cause}, 8'h01);

    // Staged release at 8 / 12 / 16.
    cyc(7);  check("mem_c7", {7'b0, rst_mem}, 8'h01);
    cyc(1);  check("mem_c8", {6'b0, rst_mem, rst_periph}, 8'h01);
    cyc(3);  check("periph_c11", {7'b0, rst_periph}, 8'h01);
    cyc(1);  check("periph_c12", {6'b0, rst_periph, rst_cpu}, 8'h01);
    cyc(3);  check("cpu_c15", {6'b0, rst_cpu, busy}, 8'h03);
    cyc(1);  check("cpu_c16", {6'b0, rst_cpu, busy}, 8'h00);
    check("cause_por", {4'b0, cause}, 8'h01);

    // Watchdog in RUN replays the sequence.
    cyc(5);
    req_wdt = 1'b1; cyc(1); req_wdt = 1'b0;
    check("wdt_assert", {4'b0, rst_mem, rst_periph, rst_cpu, busy}, 8'h0F);
    check("wdt_cause", {4'b0, cause}, 8'h05);
    cyc(7);  check("wdt_mem_c7", {7'b0, rst_mem}, 8'h01);
    cyc(1);  check("wdt_mem_c8", {7'b0, rst_mem}, 8'h00);

    // Software request mid-sequence restarts it.
    cyc(20);
    req_wdt = 1'b1; cyc(1); req_wdt = 1'b0;
    cyc(10); check("mid_mem_low", {7'b0, rst_mem}, 8'h00);
    req_sw = 1'b1; cyc(1); req_sw = 1'b0;
    check("mid_restart", {4'b0, rst_mem, rst_periph, rst_cpu, busy}, 8'h0F);
    check("mid_cause", {4'b0, cause}, 8'h07);
    cyc(20);
    clr_cause = 1'b1; cyc(1); clr_cause = 1'b0;
    check("clr_cause", {4'b0, cause}, 8'h01);

    // Button: 15 cycles is too short, 40 cycles gives one sequence.
    cyc(5);
    req_ext = 1'b1; cyc(15); req_ext = 1'b0;
    cyc(25);
    check("ext_short", {3'b0, cause[3], rst_mem, rst_periph, rst_cpu, busy}, 8'h00);
    rises = 0;
    prev_cpu = rst_cpu;
    req_ext = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (i == 40) req_ext = 1'b0;
      cyc(1);
      if (rst_cpu && !prev_cpu) rises++;
      prev_cpu = rst_cpu;
    end
    check("ext_one_seq", rises[7:0], 8'h01);
    check("ext_cause", {4'b0, cause}, 8'h09);

    // Set wins over a coincident clear.
    req_sw = 1'b1; req_wdt = 1'b1; clr_cause = 1'b1;
    cyc(1);
    req_sw = 1'b0; req_wdt = 1'b0; clr_cause = 1'b0;
    check("set_wins", {4'b0, cause}, 8'h07);
    cyc(3);
    clr_cause = 1'b1; cyc(1); clr_cause = 1'b0;
    check("lone_clr", {4'b0, cause}, 8'h01);

    // Randomized traffic, checked by the model every cycle.
    ext_left = 0;
    for (int i = 0; i < 4000; i++) begin
      cyc(1);
      req_sw    = ($urandom_range(0, 59) == 0);
      req_wdt   = ($urandom_range(0, 59) == 0);
      clr_cause = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      if (ext_left == 0) begin
        req_ext  = ~req_ext;
        ext_left = $urandom_range(1, 40);
      end else begin
        ext_left--;
      end
    end
    req_sw = 1'b0; req_wdt = 1'b0; clr_cause = 1'b0; rst = 1'b0; req_ext = 1'b0;
    cyc(60);
    check("final_run", {6'b0, rst_cpu, busy}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
